// File: rtl/audio_ctrl_pkg.sv
// Shared command codes, mode encodings, response bytes and FSM states for the
// audio mode controller.
package audio_ctrl_pkg;

  localparam logic [3:0] CMD_EFFECT  = 4'b0010;
  localparam logic [3:0] CMD_ETH_ON  = 4'b0100;
  localparam logic [3:0] CMD_ETH_OFF = 4'b1000;
  localparam logic [3:0] CMD_VOICE   = 4'b1001;

  localparam logic [2:0] MODE_BYPASS = 3'd0;
  localparam logic [2:0] MODE_TONE   = 3'd1;
  localparam logic [2:0] MODE_ECHO   = 3'd2;
  localparam logic [2:0] MODE_BGM    = 3'd3;
  localparam logic [2:0] MODE_VOICE  = 3'd4;

  localparam logic [3:0] RSP_MODE_HDR = 4'hA;
  localparam logic [3:0] RSP_ETH_HDR  = 4'hB;
  localparam logic [7:0] RSP_NACK     = 8'hEE;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StMuteWait,
    StSwitch,
    StSettleWait,
    StResp
  } state_e;

  // Enable vector ordered {voice, bgm, echo, tone}; bypass and unknown modes give all-zero.
  function automatic logic [3:0] mode_enables(input logic [2:0] mode);
    logic [3:0] en;
    en = 4'b0000;
    case (mode)
      MODE_TONE:  en = 4'b0001;
      MODE_ECHO:  en = 4'b0010;
      MODE_BGM:   en = 4'b0100;
      MODE_VOICE: en = 4'b1000;
      default:    en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [7:0] mode_ack(input logic [2:0] mode);
    return {RSP_MODE_HDR, 1'b0, mode};
  endfunction

endpackage

// File: rtl/cdc_edge_sync.sv
// Two-flop synchronizer for an asynchronous strobe, plus a one-cycle pulse on
// each synchronized rising edge.
module cdc_edge_sync (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/audio_mode_ctrl.sv
// Sequences UART-requested audio mode changes with muted, LRCK-frame-aligned
// switching, Ethernet streaming control and an ACK/NACK response byte.
module audio_mode_ctrl
  import audio_ctrl_pkg::*;
#(
  parameter int unsigned MUTE_FRAMES   = 4,
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned TIMEOUT_CYC   = 16384,
  parameter int unsigned TO_W          = 14
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  input  logic [3:0] ctrl_cmd,
  input  logic [3:0] value_cmd,
  output logic       cmd_ready,
  input  logic       lrck_in,
  input  logic       codec_ready,
  output logic [2:0] path_sel,
  output logic       tone_en,
  output logic       echo_en,
  output logic       bgm_en,
  output logic       voice_en,
  output logic       eth_en,
  output logic       mute,
  output logic       busy,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       rsp_ready
);

  localparam logic [3:0]      MuteLast   = 4'(MUTE_FRAMES - 1);
  localparam logic [3:0]      SettleLast = 4'(SETTLE_FRAMES - 1);
  localparam logic [TO_W-1:0] ToLast     = TO_W'(TIMEOUT_CYC - 1);

  state_e          r_state;
  logic [3:0]      r_ctrl;
  logic [3:0]      r_value;
  logic [2:0]      r_target;
  logic            r_skip_mute;
  logic [3:0]      r_frame_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [2:0]      r_path_sel;
  logic [3:0]      r_en;
  logic            r_eth_en;
  logic            r_mute;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_data;

  logic            w_tick;
  logic            w_is_mode;
  logic [2:0]      w_target;
  logic [3:0]      w_last;
  logic            w_wait_done;

  cdc_edge_sync u_lrck_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_async (lrck_in),
    .o_rise  (w_tick)
  );

  always_comb begin
    w_is_mode = 1'b0;
    w_target  = MODE_BYPASS;
    if (r_ctrl == CMD_EFFECT && r_value[3:2] == 2'b00) begin
      w_is_mode = 1'b1;
      w_target  = {1'b0, r_value[1:0]};
    end else if (r_ctrl == CMD_VOICE) begin
      w_is_mode = 1'b1;
      w_target  = MODE_VOICE;
    end
  end

  // A stalled LRCK still lets the wait finish once the cycle budget runs out.
  always_comb begin
    w_last      = (r_state == StMuteWait) ? MuteLast : SettleLast;
    w_wait_done = (w_tick && r_frame_cnt == w_last) || (r_to_cnt == ToLast);
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= StIdle;
      r_ctrl      <= 4'd0;
      r_value     <= 4'd0;
      r_target    <= MODE_BYPASS;
      r_skip_mute <= 1'b0;
      r_frame_cnt <= 4'd0;
      r_to_cnt    <= '0;
      r_path_sel  <= MODE_BYPASS;
      r_en        <= 4'b0000;
      r_eth_en    <= 1'b0;
      r_mute      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_ctrl  <= ctrl_cmd;
            r_value <= value_cmd;
            r_state <= StDecode;
          end
        end
        StDecode: begin
          r_frame_cnt <= 4'd0;
          r_to_cnt    <= '0;
          r_target    <= w_target;
          r_skip_mute <= 1'b0;
          if (w_is_mode) begin
            if (w_target == r_path_sel) begin
              r_rsp_data  <= mode_ack(r_path_sel);
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end else if (!codec_ready) begin
              r_skip_mute <= 1'b1;
              r_state     <= StSwitch;
            end else begin
              r_mute  <= 1'b1;
              r_state <= StMuteWait;
            end
          end else if (r_ctrl == CMD_ETH_ON || r_ctrl == CMD_ETH_OFF) begin
            r_eth_en    <= (r_ctrl == CMD_ETH_ON);
            r_rsp_data  <= {RSP_ETH_HDR, 3'b000, (r_ctrl == CMD_ETH_ON)};
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_rsp_data  <= RSP_NACK;
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end
        end
        StMuteWait, StSettleWait: begin
          if (w_wait_done) begin
            r_frame_cnt <= 4'd0;
            r_to_cnt    <= '0;
            if (r_state == StMuteWait) begin
              r_state <= StSwitch;
            end else begin
              r_mute      <= 1'b0;
              r_rsp_data  <= mode_ack(r_path_sel);
              r_rsp_valid <= 1'b1;
              r_state     <= StResp;
            end
          end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 4'd1;
            r_to_cnt    <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        StSwitch: begin
          r_path_sel <= r_target;
          r_en       <= mode_enables(r_target);
          if (r_skip_mute || SETTLE_FRAMES == 0) begin
            r_mute      <= 1'b0;
            r_rsp_data  <= mode_ack(r_target);
            r_rsp_valid <= 1'b1;
            r_state     <= StResp;
          end else begin
            r_state <= StSettleWait;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (r_state == StIdle);
  assign busy      = (r_state != StIdle);
  assign path_sel  = r_path_sel;
  assign tone_en   = r_en[0];
  assign echo_en   = r_en[1];
  assign bgm_en    = r_en[2];
  assign voice_en  = r_en[3];
  assign eth_en    = r_eth_en;
  assign mute      = r_mute;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_audio_mode_ctrl.sv
// Directed-vector bench for audio_mode_ctrl: mode switching with LRCK framing,
// repeats, NACKs, Ethernet control, LRCK-stall timeout and asynchronous reset.
module tb_audio_mode_ctrl;

  logic       sys_clk     = 1'b0;
  logic       sys_rst     = 1'b0;
  logic       cmd_valid   = 1'b0;
  logic [3:0] ctrl_cmd    = 4'd0;
  logic [3:0] value_cmd   = 4'd0;
  logic       lrck_in     = 1'b0;
  logic       codec_ready = 1'b1;
  logic       rsp_ready   = 1'b0;
  logic       cmd_ready;
  logic [2:0] path_sel;
  logic       tone_en, echo_en, bgm_en, voice_en;
  logic       eth_en, mute, busy, rsp_valid;
  logic [7:0] rsp_data;

  int n_vec      = 0;
  int n_err      = 0;
  int mute_total = 0;
  int onehot_err = 0;
  bit lrck_run   = 1'b1;

  audio_mode_ctrl dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .ctrl_cmd    (ctrl_cmd),
    .value_cmd   (value_cmd),
    .cmd_ready   (cmd_ready),
    .lrck_in     (lrck_in),
    .codec_ready (codec_ready),
    .path_sel    (path_sel),
    .tone_en     (tone_en),
    .echo_en     (echo_en),
    .bgm_en      (bgm_en),
    .voice_en    (voice_en),
    .eth_en      (eth_en),
    .mute        (mute),
    .busy        (busy),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready)
  );

  always #10 sys_clk = ~sys_clk;

  // 48 kHz LRCK: half period ~10.417 us.
  always begin
    #10417;
    if (lrck_run) lrck_in = ~lrck_in;
  end

  always @(negedge sys_clk) begin
    if (mute) mute_total++;
    if (!$onehot0({voice_en, bgm_en, echo_en, tone_en})) onehot_err++;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [3:0] c, input logic [3:0] v);
    int n;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      tick(1);
      n++;
    end
    if (!cmd_ready) check_vec("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    ctrl_cmd  = c;
    value_cmd = v;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp, input int max_cyc);
    int n;
    n = 0;
    while (!rsp_valid && n < max_cyc) begin
      tick(1);
      n++;
    end
    check_vec({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check_vec(tag, 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check_vec({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic lrck_align();
    @(posedge lrck_in);
    tick(20);
  endtask

  initial begin
    int m0;
    int d;
    int hold_bad;

    // Reset values while sys_rst is held low.
    tick(3);
    check_vec("rst_path", 32'(path_sel), 32'd0);
    check_vec("rst_en", 32'({voice_en, bgm_en, echo_en, tone_en}), 32'd0);
    check_vec("rst_flags", 32'({eth_en, mute, busy, rsp_valid}), 32'd0);
    check_vec("rst_ready", 32'(cmd_ready), 32'd1);
    check_vec("rst_data", 32'(rsp_data), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick(2);

    // Tone: mute, switch on the 4th frame, settle 2 frames, respond A1.
    lrck_align();
    send_cmd(4'h2, 4'h1);
    tick(2);
    check_vec("tone_mute_on", 32'(mute), 32'd1);
    repeat (3) @(posedge lrck_in);
    tick(10);
    check_vec("tone_pre_switch", 32'({path_sel, tone_en}), 32'({3'd0, 1'b0}));
    @(posedge lrck_in);
    tick(10);
    check_vec("tone_switched", 32'({path_sel, tone_en, mute}), 32'({3'd1, 1'b1, 1'b1}));
    @(posedge lrck_in);
    tick(10);
    check_vec("tone_settle1", 32'({mute, rsp_valid}), 32'({1'b1, 1'b0}));
    @(posedge lrck_in);
    tick(10);
    check_vec("tone_unmute", 32'({mute, rsp_valid}), 32'({1'b0, 1'b1}));
    hold_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'hA1 || cmd_ready !== 1'b0 || busy !== 1'b1)
        hold_bad++;
      tick(1);
    end
    check_vec("resp_hold", 32'(hold_bad), 32'd0);
    wait_rsp("tone_rsp", 8'hA1, 10);
    check_vec("tone_idle_ready", 32'(cmd_ready), 32'd1);

    // Same mode again: immediate ACK, no mute.
    m0 = mute_total;
    send_cmd(4'h2, 4'h1);
    wait_rsp("same_rsp", 8'hA1, 20);
    check_vec("same_no_mute", 32'(mute_total - m0), 32'd0);
    check_vec("same_en", 32'({voice_en, bgm_en, echo_en, tone_en}), 32'b0001);

    // Bad value and bad class both NACK without disturbing the mode.
    send_cmd(4'h2, 4'h7);
    wait_rsp("nack_val", 8'hEE, 20);
    send_cmd(4'h3, 4'h0);
    wait_rsp("nack_ctrl", 8'hEE, 20);
    check_vec("nack_keep", 32'({path_sel, voice_en, bgm_en, echo_en, tone_en}),
              32'({3'd1, 4'b0001}));

    // Echo, then Ethernet on/off leaves echo alone and never mutes.
    lrck_align();
    send_cmd(4'h2, 4'h2);
    wait_rsp("echo_rsp", 8'hA2, 8000);
    check_vec("echo_en", 32'({path_sel, voice_en, bgm_en, echo_en, tone_en}), 32'({3'd2, 4'b0010}));
    m0 = mute_total;
    send_cmd(4'h4, 4'h0);
    tick(2);
    check_vec("eth_on_fast", 32'(eth_en), 32'd1);
    wait_rsp("eth_on", 8'hB1, 20);
    check_vec("eth_echo_kept", 32'(echo_en), 32'd1);
    send_cmd(4'h8, 4'h0);
    wait_rsp("eth_off", 8'hB0, 20);
    check_vec("eth_off_val", 32'(eth_en), 32'd0);
    check_vec("eth_no_mute", 32'(mute_total - m0), 32'd0);

    // LRCK stalled: both waits end by timeout, ~2 x 16384 muted cycles.
    lrck_run = 1'b0;
    tick(10);
    m0 = mute_total;
    send_cmd(4'h9, 4'h0);
    wait_rsp("voice_rsp", 8'hA4, 40000);
    check_vec("voice_en", 32'({path_sel, voice_en, bgm_en, echo_en, tone_en}), 32'({3'd4, 4'b1000}));
    d = mute_total - m0;
    check_vec("timeout_mute_len", 32'(d >= 32768 && d <= 32772), 32'd1);

    // Asynchronous reset in the middle of the mute wait.
    lrck_run = 1'b1;
    lrck_align();
    send_cmd(4'h2, 4'h3);
    tick(50);
    check_vec("midrst_pre", 32'({mute, busy}), 32'({1'b1, 1'b1}));
    #4 sys_rst = 1'b0;
    #1;
    check_vec("midrst_out", 32'({path_sel, voice_en, mute, busy, rsp_valid}), 32'd0);
    check_vec("midrst_ready", 32'(cmd_ready), 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    tick(2);
    check_vec("postrst", 32'({cmd_ready, path_sel, eth_en}), 32'({1'b1, 3'd0, 1'b0}));

    // Codec not ready: switch directly, no mute.
    codec_ready = 1'b0;
    m0 = mute_total;
    send_cmd(4'h2, 4'h1);
    wait_rsp("nocodec_rsp", 8'hA1, 20);
    check_vec("nocodec_en", 32'({path_sel, tone_en}), 32'({3'd1, 1'b1}));
    check_vec("nocodec_no_mute", 32'(mute_total - m0), 32'd0);

    check_vec("onehot0", 32'(onehot_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
